// File: rtl/ir_tx_sched_pkg.sv
// Shared state encoding, counter width and 50 MHz timing constants for the
// IR TX scheduler.
package ir_tx_sched_pkg;

  localparam int unsigned CNT_W                 = 32;
  localparam int unsigned GAP_CYCLES_DEFAULT    = 500000;
  localparam int unsigned START_TIMEOUT_DEFAULT = 8;
  localparam int unsigned FRAME_TIMEOUT_DEFAULT = 1000000;
  localparam int unsigned FRAME_MAX_CYCLES      = 800000;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/ir_tx_rr_arbiter.sv
// Winner select for the IR TX scheduler: round-robin from a registered pointer,
// or lowest-index fixed priority when TX_SCHED_FIXED_PRIO_EN is defined.
module ir_tx_rr_arbiter
  import ir_tx_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_upd,
  input  logic [IDX_W-1:0]   i_upd_idx,
  output logic [IDX_W-1:0]   o_win_idx,
  output logic               o_win_valid
);

  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_win;
  logic             w_found;

`ifdef TX_SCHED_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{i_clk, i_reset, i_upd, i_upd_idx};

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end
`else
  // r_ptr is the index currently holding highest priority.
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= IDX_W'(rr_index(32'(i_upd_idx), 1, NUM_REQ));
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'(rr_index(32'(r_ptr), k, NUM_REQ));
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end
`endif

  assign o_win_idx   = w_win;
  assign o_win_valid = w_found;

endmodule

// File: rtl/ir_tx_scheduler.sv
// Shares one IR transmit serializer among NUM_REQ requesters: arbitration,
// launch, busy tracking, inter-frame gap and timeouts. Build option:
// TX_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority in the arbiter.
module ir_tx_scheduler
  import ir_tx_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ       = 4,
  parameter  int unsigned GAP_CYCLES    = GAP_CYCLES_DEFAULT,
  parameter  int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT,
  parameter  int unsigned FRAME_TIMEOUT = FRAME_TIMEOUT_DEFAULT,
  localparam int unsigned IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                 CLK_50M,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [IDX_W-1:0]     err_id,
  output logic                 tx_send_en,
  output logic [7:0]           tx_din,
  input  logic                 tx_busy,
  output logic                 sched_busy
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_win;
  logic [7:0]         r_din;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic [IDX_W-1:0]   r_err_id;
  logic               r_send_en;
  logic               r_sched_busy;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_win;
  logic               w_win_valid;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  ir_tx_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_clk      (CLK_50M),
    .i_reset    (reset),
    .i_req      (req),
    .i_upd      (r_state == LAUNCH),
    .i_upd_idx  (r_win),
    .o_win_idx  (w_win),
    .o_win_valid(w_win_valid)
  );

  // Each limit counts whole cycles spent in the state; the exit (and any
  // err/done pulse) appears in the cycle after the last counted one.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_win        <= '0;
      r_din        <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_err        <= 1'b0;
      r_err_id     <= '0;
      r_send_en    <= 1'b0;
      r_sched_busy <= 1'b0;
    end else begin
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_err_id  <= '0;
      r_send_en <= 1'b0;
      r_cnt     <= w_cnt_inc;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_win_valid) begin
            r_win          <= w_win;
            r_din          <= req_data[{w_win, 3'b000} +: 8];
            r_grant[w_win] <= 1'b1;
            r_send_en      <= 1'b1;
            r_sched_busy   <= 1'b1;
            r_state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else if (w_cnt_inc >= START_TIMEOUT) begin
            r_err    <= 1'b1;
            r_err_id <= r_win;
            r_cnt    <= '0;
            r_state  <= GAP;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            r_done[r_win] <= 1'b1;
            r_cnt         <= '0;
            r_state       <= GAP;
          end else if (w_cnt_inc >= FRAME_TIMEOUT) begin
            r_err    <= 1'b1;
            r_err_id <= r_win;
            r_cnt    <= '0;
            r_state  <= GAP;
          end
        end
        GAP: begin
          if (w_cnt_inc >= GAP_CYCLES) begin
            r_cnt        <= '0;
            r_sched_busy <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_cnt        <= '0;
          r_sched_busy <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign err        = r_err;
  assign err_id     = r_err_id;
  assign tx_send_en = r_send_en;
  assign tx_din     = r_din;
  assign sched_busy = r_sched_busy;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler with a behavioural serializer model and
// launch/completion scoreboards.
module tb_ir_tx_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned GAP = 20;
  localparam int unsigned ST  = 8;
  localparam int unsigned FT  = 100;

  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_IDLE  = 3;
  localparam int EV_BUSY  = 4;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } launch_t;

  typedef struct {
    bit is_err;
    int idx;
  } cpl_t;

  logic           CLK_50M  = 1'b0;
  logic           reset    = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [N*8-1:0] req_data = '0;
  logic           tx_busy  = 1'b0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           err;
  logic [1:0]     err_id;
  logic           tx_send_en;
  logic [7:0]     tx_din;
  logic           sched_busy;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  int          model_mode = 0;
  int          busy_len   = 40;
  int          bcnt       = 0;
  int unsigned last_rise  = 0;
  int unsigned last_fall  = 0;
  logic        prev_busy  = 1'b0;

  launch_t g_q[$];
  cpl_t    c_q[$];

  ir_tx_scheduler #(
    .NUM_REQ      (N),
    .GAP_CYCLES   (GAP),
    .START_TIMEOUT(ST),
    .FRAME_TIMEOUT(FT)
  ) dut (
    .CLK_50M   (CLK_50M),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .err_id    (err_id),
    .tx_send_en(tx_send_en),
    .tx_din    (tx_din),
    .tx_busy   (tx_busy),
    .sched_busy(sched_busy)
  );

  always #10 CLK_50M = ~CLK_50M;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  // Serializer model: mode 0 normal, 1 never starts, 2 busy stuck high.
  always @(posedge CLK_50M) begin
    if (reset) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_send_en && model_mode != 1) begin
      tx_busy <= 1'b1;
      bcnt    <= busy_len;
    end else if (tx_busy && model_mode == 0) begin
      if (bcnt <= 1) tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  task automatic expect_launch(input int idx, input logic [7:0] data);
    launch_t g;
    g.idx  = idx;
    g.data = data;
    g_q.push_back(g);
  endtask

  task automatic expect_cpl(input bit is_err, input int idx);
    cpl_t c;
    c.is_err = is_err;
    c.idx    = idx;
    c_q.push_back(c);
  endtask

  task automatic wait_ev(input string tag, input int sel, input int unsigned budget,
                         output int unsigned at);
    bit hit;
    hit = 1'b0;
    at  = 0;
    for (int unsigned i = 0; i < budget && !hit; i++) begin
      @(negedge CLK_50M);
      case (sel)
        EV_GRANT: hit = (grant != '0);
        EV_DONE:  hit = (done != '0);
        EV_ERR:   hit = err;
        EV_IDLE:  hit = !sched_busy;
        default:  hit = tx_busy;
      endcase
    end
    if (hit) at = cyc;
    check({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  always @(negedge CLK_50M) begin
    if (tx_busy && !prev_busy) last_rise = cyc;
    if (!tx_busy && prev_busy) last_fall = cyc;
    prev_busy = tx_busy;
    if (grant != '0 || tx_send_en) begin
      if (g_q.size() == 0) begin
        check("launch_unexpected", {grant, tx_send_en}, 0);
      end else begin
        launch_t g;
        g = g_q.pop_front();
        check("grant_vec", 32'(grant), 32'(1) << g.idx);
        check("send_en", 32'(tx_send_en), 32'd1);
        check("tx_din", 32'(tx_din), 32'(g.data));
      end
    end
    if (done != '0 || err) begin
      if (c_q.size() == 0) begin
        check("completion_unexpected", {done, err}, 0);
      end else begin
        cpl_t c;
        c = c_q.pop_front();
        if (c.is_err) begin
          check("err_pulse", 32'(err), 32'd1);
          check("err_id", 32'(err_id), 32'(c.idx));
          check("err_no_done", 32'(done), 32'd0);
        end else begin
          check("done_vec", 32'(done), 32'(1) << c.idx);
          check("done_no_err", 32'(err), 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, ta, td, te, ti, act;
    int          order[$];

    repeat (2) @(negedge CLK_50M);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_id", 32'(err_id), 0);
    check("rst_send_en", 32'(tx_send_en), 0);
    check("rst_tx_din", 32'(tx_din), 0);
    check("rst_sched_busy", 32'(sched_busy), 0);
    reset = 1'b0;

    // Single requester, normal frame, then gap enforcement.
    model_mode = 0;
    busy_len   = 40;
    @(negedge CLK_50M);
    set_byte(1, 8'hA5);
    req = 4'b0010;
    t   = cyc;
    expect_launch(1, 8'hA5);
    expect_cpl(1'b0, 1);
    wait_ev("t1_grant", EV_GRANT, 10, ta);
    check("t1_grant_latency", ta, t + 1);
    req = '0;
    @(negedge CLK_50M);
    check("t1_send_en_pulse", 32'(tx_send_en), 0);
    check("t1_grant_pulse", 32'(grant), 0);
    wait_ev("t1_done", EV_DONE, 100, td);
    check("t1_done_after_fall", td, last_fall + 1);
    check("t1_busy_len", last_fall - last_rise, 40);
    set_byte(1, 8'h3C);
    req = 4'b0010;
    expect_launch(1, 8'h3C);
    expect_cpl(1'b0, 1);
    wait_ev("t1_regrant", EV_GRANT, 60, ta);
    check("t1_gap", ta, td + GAP + 1);
    req = '0;
    wait_ev("t1_done2", EV_DONE, 100, td);
    wait_ev("t1_idle", EV_IDLE, 60, ti);

    // All requesters continuously active after reset.
    reset = 1'b1;
    @(negedge CLK_50M);
    reset    = 1'b0;
    busy_len = 3;
`ifdef TX_SCHED_FIXED_PRIO_EN
    order = '{0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) set_byte(i, 8'h10 + 8'(i) * 8'h11);
    req = 4'b1111;
    foreach (order[i]) begin
      expect_launch(order[i], 8'h10 + 8'(order[i]) * 8'h11);
      expect_cpl(1'b0, order[i]);
    end
    foreach (order[i]) wait_ev("t2_grant", EV_GRANT, 100, ta);
    req = '0;
    wait_ev("t2_done", EV_DONE, 100, td);
    wait_ev("t2_idle", EV_IDLE, 60, ti);

    // Serializer never starts.
    model_mode = 1;
    set_byte(2, 8'h77);
    req = 4'b0100;
    expect_launch(2, 8'h77);
    expect_cpl(1'b1, 2);
    wait_ev("t3_grant", EV_GRANT, 10, ta);
    req = '0;
    wait_ev("t3_err", EV_ERR, 40, te);
    check("t3_err_time", te, ta + ST + 1);
    wait_ev("t3_idle", EV_IDLE, 60, ti);
    check("t3_gap", ti, te + GAP);

    // Busy stuck high, then recovery after the gap.
    model_mode = 2;
    set_byte(3, 8'h5A);
    req = 4'b1000;
    expect_launch(3, 8'h5A);
    expect_cpl(1'b1, 3);
    wait_ev("t4_grant", EV_GRANT, 10, ta);
    req = '0;
    wait_ev("t4_err", EV_ERR, 200, te);
    check("t4_err_time", te, last_rise + FT + 1);
    model_mode = 0;
    set_byte(0, 8'h66);
    req = 4'b0001;
    expect_launch(0, 8'h66);
    expect_cpl(1'b0, 0);
    wait_ev("t4_regrant", EV_GRANT, 60, ta);
    check("t4_gap", ta, te + GAP + 1);
    req = '0;
    wait_ev("t4_done", EV_DONE, 40, td);
    wait_ev("t4_idle", EV_IDLE, 60, ti);

    // Reset during WAIT_DONE; priority restarts at index 0.
    busy_len = 40;
    set_byte(2, 8'h99);
    req = 4'b0100;
    expect_launch(2, 8'h99);
    wait_ev("t5_grant", EV_GRANT, 10, ta);
    req = '0;
    wait_ev("t5_busy", EV_BUSY, 10, t);
    repeat (5) @(negedge CLK_50M);
    check("t5_mid_frame", 32'(sched_busy), 1);
    reset = 1'b1;
    @(negedge CLK_50M);
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_err", 32'(err), 0);
    check("t5_rst_send_en", 32'(tx_send_en), 0);
    check("t5_rst_tx_din", 32'(tx_din), 0);
    check("t5_rst_sched_busy", 32'(sched_busy), 0);
    reset    = 1'b0;
    busy_len = 3;
    set_byte(2, 8'hB2);
    set_byte(3, 8'hC3);
    req = 4'b1100;
    t   = cyc;
    expect_launch(2, 8'hB2);
    expect_cpl(1'b0, 2);
    wait_ev("t5_grant2", EV_GRANT, 10, ta);
    check("t5_grant_latency", ta, t + 1);
    req = '0;
    wait_ev("t5_done", EV_DONE, 40, td);
    wait_ev("t5_idle", EV_IDLE, 60, ti);

    // Withdrawn request is never served.
    set_byte(0, 8'hE0);
    req = 4'b0001;
    expect_launch(0, 8'hE0);
    expect_cpl(1'b0, 0);
    wait_ev("t6_grant", EV_GRANT, 10, ta);
    set_byte(3, 8'hF3);
    req = 4'b1000;
    repeat (3) @(negedge CLK_50M);
    req = '0;
    wait_ev("t6_done", EV_DONE, 40, td);
    wait_ev("t6_idle", EV_IDLE, 60, ti);
    act = 0;
    repeat (30) begin
      @(negedge CLK_50M);
      if (sched_busy || grant != '0) act++;
    end
    check("t6_stay_idle", act, 0);

    check("launch_q_empty", g_q.size(), 0);
    check("cpl_q_empty", c_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
